// File: rtl/reg_port_arbiter.sv
// reg_port_arbiter: shares one register-file access port between two command sources.
// Each source owns a 1-deep slot. Full slots are granted round-robin, and only one register
// op is in flight at a time. Read data is routed back to the source that issued the read.
module reg_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              i_reset_n,
    input  logic              i_req0_w_en,
    input  logic [ADDR_W-1:0] i_req0_w_addr,
    input  logic [DATA_W-1:0] i_req0_w_data,
    input  logic              i_req0_r_en,
    input  logic [ADDR_W-1:0] i_req0_r_addr,
    input  logic              i_req1_w_en,
    input  logic [ADDR_W-1:0] i_req1_w_addr,
    input  logic [DATA_W-1:0] i_req1_w_data,
    input  logic              i_req1_r_en,
    input  logic [ADDR_W-1:0] i_req1_r_addr,
    output logic              o_req0_busy,
    output logic              o_req0_drop,
    output logic [DATA_W-1:0] o_req0_r_data,
    output logic              o_req0_r_dv,
    output logic              o_req1_busy,
    output logic              o_req1_drop,
    output logic [DATA_W-1:0] o_req1_r_data,
    output logic              o_req1_r_dv,
    output logic              o_reg_w_en,
    output logic [ADDR_W-1:0] o_reg_w_addr,
    output logic [DATA_W-1:0] o_reg_w_data,
    output logic              o_reg_r_en,
    output logic [ADDR_W-1:0] o_reg_r_addr,
    input  logic [DATA_W-1:0] i_reg_r_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t state;

    logic [1:0]        req_w;
    logic [1:0]        req_r;
    logic [ADDR_W-1:0] req_w_addr [2];
    logic [ADDR_W-1:0] req_r_addr [2];
    logic [DATA_W-1:0] req_w_data [2];

    logic [1:0]        slot_full;
    logic [1:0]        slot_is_wr;
    logic [ADDR_W-1:0] slot_addr [2];
    logic [DATA_W-1:0] slot_data [2];
    logic [1:0]        drop;

    logic [1:0]        r_dv;
    logic [DATA_W-1:0] r_data [2];

    logic              cur_sel;
    logic              cur_is_wr;
    logic              last_sel;
    logic [2:0]        lat_cnt;

    logic [1:0]        release_slot;
    logic              grant_valid;
    logic              grant_sel;

    assign req_w         = {i_req1_w_en, i_req0_w_en};
    assign req_r         = {i_req1_r_en, i_req0_r_en};
    assign req_w_addr[0] = i_req0_w_addr;
    assign req_w_addr[1] = i_req1_w_addr;
    assign req_r_addr[0] = i_req0_r_addr;
    assign req_r_addr[1] = i_req1_r_addr;
    assign req_w_data[0] = i_req0_w_data;
    assign req_w_data[1] = i_req1_w_data;

    // A slot frees when its write leaves ISSUE, or when its read data is being sampled.
    always_comb begin
        release_slot = 2'b00;
        if ((state == ISSUE && cur_is_wr) || (state == WAIT_RD && lat_cnt == 3'd1)) begin
            release_slot[cur_sel] = 1'b1;
        end
    end

    // Round-robin choice: the only full slot, or the one not served last when both are full.
    always_comb begin
        grant_valid = (state == IDLE) && (|slot_full);
        if (&slot_full) begin
            grant_sel = ~last_sel;
        end else begin
            grant_sel = slot_full[1];
        end
    end

    // Slot capture/release and drop reporting. A releasing slot still counts as busy for new pulses.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            slot_full  <= '0;
            slot_is_wr <= '0;
            drop       <= '0;
            for (int n = 0; n < 2; n++) begin
                slot_addr[n] <= '0;
                slot_data[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                drop[n] <= (slot_full[n] && (req_w[n] || req_r[n])) ||
                           (!slot_full[n] && req_w[n] && req_r[n]);
                if (release_slot[n]) begin
                    slot_full[n] <= 1'b0;
                end else if (!slot_full[n] && (req_w[n] || req_r[n])) begin
                    slot_full[n]  <= 1'b1;
                    slot_is_wr[n] <= req_w[n];
                    slot_addr[n]  <= req_w[n] ? req_w_addr[n] : req_r_addr[n];
                    slot_data[n]  <= req_w_data[n];
                end
            end
        end
    end

    // Port FSM: grant in IDLE with the strobe registered at that edge, then finish the op.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            cur_sel      <= 1'b0;
            cur_is_wr    <= 1'b0;
            last_sel     <= 1'b1;
            lat_cnt      <= '0;
            o_reg_w_en   <= 1'b0;
            o_reg_w_addr <= '0;
            o_reg_w_data <= '0;
            o_reg_r_en   <= 1'b0;
            o_reg_r_addr <= '0;
            r_dv         <= '0;
            r_data[0]    <= '0;
            r_data[1]    <= '0;
        end else begin
            o_reg_w_en <= 1'b0;
            o_reg_r_en <= 1'b0;
            r_dv       <= '0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        cur_sel   <= grant_sel;
                        last_sel  <= grant_sel;
                        cur_is_wr <= slot_is_wr[grant_sel];
                        if (slot_is_wr[grant_sel]) begin
                            o_reg_w_en   <= 1'b1;
                            o_reg_w_addr <= slot_addr[grant_sel];
                            o_reg_w_data <= slot_data[grant_sel];
                        end else begin
                            o_reg_r_en   <= 1'b1;
                            o_reg_r_addr <= slot_addr[grant_sel];
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cur_is_wr) begin
                        state <= IDLE;
                    end else begin
                        lat_cnt <= 3'(READ_LAT);
                        state   <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (lat_cnt == 3'd1) begin
                        r_data[cur_sel] <= i_reg_r_data;
                        r_dv[cur_sel]   <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_req0_busy   = slot_full[0];
    assign o_req1_busy   = slot_full[1];
    assign o_req0_drop   = drop[0];
    assign o_req1_drop   = drop[1];
    assign o_req0_r_dv   = r_dv[0];
    assign o_req1_r_dv   = r_dv[1];
    assign o_req0_r_data = r_data[0];
    assign o_req1_r_data = r_data[1];

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Testbench for reg_port_arbiter: directed scenarios followed by random traffic, every cycle
// compared against a transaction-timing reference model (slot occupancy plus release times).
module tb_reg_port_arbiter;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int READ_LAT = 1;

    logic              clk = 1'b0;
    logic              i_reset_n;
    logic              i_req0_w_en, i_req0_r_en, i_req1_w_en, i_req1_r_en;
    logic [ADDR_W-1:0] i_req0_w_addr, i_req0_r_addr, i_req1_w_addr, i_req1_r_addr;
    logic [DATA_W-1:0] i_req0_w_data, i_req1_w_data;
    logic              o_req0_busy, o_req0_drop, o_req0_r_dv;
    logic              o_req1_busy, o_req1_drop, o_req1_r_dv;
    logic [DATA_W-1:0] o_req0_r_data, o_req1_r_data;
    logic              o_reg_w_en, o_reg_r_en;
    logic [ADDR_W-1:0] o_reg_w_addr, o_reg_r_addr;
    logic [DATA_W-1:0] o_reg_w_data;
    logic [DATA_W-1:0] i_reg_r_data;

    int checks   = 0;
    int failures = 0;

    reg_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .i_reset_n(i_reset_n),
        .i_req0_w_en(i_req0_w_en), .i_req0_w_addr(i_req0_w_addr), .i_req0_w_data(i_req0_w_data),
        .i_req0_r_en(i_req0_r_en), .i_req0_r_addr(i_req0_r_addr),
        .i_req1_w_en(i_req1_w_en), .i_req1_w_addr(i_req1_w_addr), .i_req1_w_data(i_req1_w_data),
        .i_req1_r_en(i_req1_r_en), .i_req1_r_addr(i_req1_r_addr),
        .o_req0_busy(o_req0_busy), .o_req0_drop(o_req0_drop),
        .o_req0_r_data(o_req0_r_data), .o_req0_r_dv(o_req0_r_dv),
        .o_req1_busy(o_req1_busy), .o_req1_drop(o_req1_drop),
        .o_req1_r_data(o_req1_r_data), .o_req1_r_dv(o_req1_r_dv),
        .o_reg_w_en(o_reg_w_en), .o_reg_w_addr(o_reg_w_addr), .o_reg_w_data(o_reg_w_data),
        .o_reg_r_en(o_reg_r_en), .o_reg_r_addr(o_reg_r_addr), .i_reg_r_data(i_reg_r_data)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Register file attached to the shared port, single-cycle read latency.
    logic [DATA_W-1:0] rf [256] = '{default: '0};
    logic [DATA_W-1:0] rd_q = '0;
    always @(posedge clk) begin
        if (o_reg_w_en) rf[o_reg_w_addr] <= o_reg_w_data;
        if (o_reg_r_en) rd_q <= rf[o_reg_r_addr];
    end
    assign i_reg_r_data = rd_q;

    // Reference model: slot occupancy, the edge at which each slot frees, and the earliest grant edge.
    logic [DATA_W-1:0] ref_mem [256];
    int                cyc;
    bit                m_full [2];
    bit                m_isw [2];
    logic [ADDR_W-1:0] m_addr [2];
    logic [DATA_W-1:0] m_data [2];
    logic [DATA_W-1:0] m_rd_val [2];
    int                m_rel [2];
    int                m_free;
    int                m_last;

    logic              e_w_en, e_r_en;
    logic [ADDR_W-1:0] e_w_addr, e_r_addr;
    logic [DATA_W-1:0] e_w_data;
    logic              e_busy [2];
    logic              e_drop [2];
    logic              e_dv [2];
    logic [DATA_W-1:0] e_rdata [2];

    bit                s_w [2];
    bit                s_r [2];
    logic [ADDR_W-1:0] s_wa [2];
    logic [ADDR_W-1:0] s_ra [2];
    logic [DATA_W-1:0] s_wd [2];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int n = 0; n < 2; n++) begin
            m_full[n] = 0; m_isw[n] = 0; m_rel[n] = -1;
            e_busy[n] = 0; e_drop[n] = 0; e_dv[n] = 0; e_rdata[n] = '0;
        end
        m_free = 0; m_last = 1;
        e_w_en = 0; e_r_en = 0; e_w_addr = '0; e_r_addr = '0; e_w_data = '0;
    endtask

    task automatic modelEdge();
        bit pf [2];
        int g;
        for (int n = 0; n < 2; n++) begin
            pf[n] = m_full[n];
            e_drop[n] = 0;
            e_dv[n] = 0;
        end
        e_w_en = 0;
        e_r_en = 0;
        // completions scheduled for this edge
        for (int n = 0; n < 2; n++) begin
            if (m_full[n] && m_rel[n] == cyc) begin
                m_full[n] = 0;
                m_rel[n] = -1;
                if (!m_isw[n]) begin
                    e_dv[n] = 1;
                    e_rdata[n] = m_rd_val[n];
                end
            end
        end
        // new grant once the port is free
        if (cyc >= m_free && (pf[0] || pf[1])) begin
            if (pf[0] && pf[1]) g = 1 - m_last;
            else g = pf[1] ? 1 : 0;
            m_last = g;
            if (m_isw[g]) begin
                e_w_en = 1; e_w_addr = m_addr[g]; e_w_data = m_data[g];
                ref_mem[m_addr[g]] = m_data[g];
                m_rel[g] = cyc + 1;
                m_free = cyc + 2;
            end else begin
                e_r_en = 1; e_r_addr = m_addr[g];
                m_rd_val[g] = ref_mem[m_addr[g]];
                m_rel[g] = cyc + 1 + READ_LAT;
                m_free = cyc + 2 + READ_LAT;
            end
        end
        // captures, judged on occupancy before this edge
        for (int n = 0; n < 2; n++) begin
            if (s_w[n] || s_r[n]) begin
                if (pf[n]) begin
                    e_drop[n] = 1;
                end else begin
                    m_full[n] = 1;
                    m_isw[n] = s_w[n];
                    m_addr[n] = s_w[n] ? s_wa[n] : s_ra[n];
                    m_data[n] = s_wd[n];
                    if (s_w[n] && s_r[n]) e_drop[n] = 1;
                end
            end
            e_busy[n] = m_full[n];
        end
    endtask

    task automatic checkAll();
        checkOutput("w_en", 64'(o_reg_w_en), 64'(e_w_en));
        checkOutput("w_addr", 64'(o_reg_w_addr), 64'(e_w_addr));
        checkOutput("w_data", 64'(o_reg_w_data), 64'(e_w_data));
        checkOutput("r_en", 64'(o_reg_r_en), 64'(e_r_en));
        checkOutput("r_addr", 64'(o_reg_r_addr), 64'(e_r_addr));
        checkOutput("busy0", 64'(o_req0_busy), 64'(e_busy[0]));
        checkOutput("busy1", 64'(o_req1_busy), 64'(e_busy[1]));
        checkOutput("drop0", 64'(o_req0_drop), 64'(e_drop[0]));
        checkOutput("drop1", 64'(o_req1_drop), 64'(e_drop[1]));
        checkOutput("r_dv0", 64'(o_req0_r_dv), 64'(e_dv[0]));
        checkOutput("r_dv1", 64'(o_req1_r_dv), 64'(e_dv[1]));
        checkOutput("r_data0", 64'(o_req0_r_data), 64'(e_rdata[0]));
        checkOutput("r_data1", 64'(o_req1_r_data), 64'(e_rdata[1]));
    endtask

    // Drive one cycle of source pulses, advance one edge, then compare all outputs.
    task automatic applyStimulus(input bit w0, input bit r0, input logic [ADDR_W-1:0] wa0,
                                 input logic [ADDR_W-1:0] ra0, input logic [DATA_W-1:0] wd0,
                                 input bit w1, input bit r1, input logic [ADDR_W-1:0] wa1,
                                 input logic [ADDR_W-1:0] ra1, input logic [DATA_W-1:0] wd1);
        s_w[0] = w0; s_r[0] = r0; s_wa[0] = wa0; s_ra[0] = ra0; s_wd[0] = wd0;
        s_w[1] = w1; s_r[1] = r1; s_wa[1] = wa1; s_ra[1] = ra1; s_wd[1] = wd1;
        i_req0_w_en = w0; i_req0_r_en = r0; i_req0_w_addr = wa0; i_req0_r_addr = ra0; i_req0_w_data = wd0;
        i_req1_w_en = w1; i_req1_r_en = r1; i_req1_w_addr = wa1; i_req1_r_addr = ra1; i_req1_w_data = wd1;
        @(posedge clk);
        if (!i_reset_n) modelReset();
        else modelEdge();
        cyc++;
        #1;
        checkAll();
        i_req0_w_en = 0; i_req0_r_en = 0; i_req1_w_en = 0; i_req1_r_en = 0;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
    endtask

    // Directed scenarios first, then random traffic on a small address set so reads hit written data.
    initial begin
        cyc = 0;
        for (int a = 0; a < 256; a++) ref_mem[a] = '0;
        i_reset_n = 1'b0;
        i_req0_w_en = 0; i_req0_r_en = 0; i_req1_w_en = 0; i_req1_r_en = 0;
        i_req0_w_addr = '0; i_req0_r_addr = '0; i_req0_w_data = '0;
        i_req1_w_addr = '0; i_req1_r_addr = '0; i_req1_w_data = '0;
        for (int n = 0; n < 2; n++) begin
            s_w[n] = 0; s_r[n] = 0; s_wa[n] = '0; s_ra[n] = '0; s_wd[n] = '0;
        end
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        i_reset_n = 1'b1;

        $display("[TB] single write from req0");
        applyStimulus(1, 0, 8'h21, 8'h00, 32'h87654321, 0, 0, '0, '0, '0);
        idleCycles(4);

        $display("[TB] single read from req1");
        applyStimulus(0, 0, '0, '0, '0, 1, 0, 8'h12, 8'h00, 32'h12345678);
        idleCycles(3);
        applyStimulus(0, 0, '0, '0, '0, 0, 1, 8'h00, 8'h12, '0);
        idleCycles(5);

        $display("[TB] simultaneous write and read, alternating grants");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 0, 8'(8'h30 + k), '0, $urandom, 0, 1, '0, 8'h21, '0);
            idleCycles(7);
        end

        $display("[TB] pulse while busy");
        applyStimulus(1, 0, 8'h40, '0, 32'hAAAA5555, 0, 0, '0, '0, '0);
        applyStimulus(1, 0, 8'h41, '0, 32'h5555AAAA, 0, 0, '0, '0, '0);
        applyStimulus(0, 1, '0, 8'h40, '0, 0, 0, '0, '0, '0);
        idleCycles(4);

        $display("[TB] write and read together on req1");
        applyStimulus(0, 0, '0, '0, '0, 1, 1, 8'h50, 8'h40, 32'hCAFEF00D);
        idleCycles(4);

        $display("[TB] reset during a read");
        applyStimulus(0, 0, '0, '0, '0, 0, 1, '0, 8'h50, '0);
        idleCycles(2);
        #2;
        i_reset_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        idleCycles(2);
        i_reset_n = 1'b1;
        idleCycles(4);
        applyStimulus(1, 0, 8'h60, '0, 32'h0BADBEEF, 0, 0, '0, '0, '0);
        idleCycles(4);

        $display("[TB] random traffic");
        for (int k = 0; k < 500; k++) begin
            bit w [2];
            bit r [2];
            for (int n = 0; n < 2; n++) begin
                int p;
                p = int'($urandom_range(0, 99));
                w[n] = (p < 20) || (p >= 40 && p < 45);
                r[n] = (p >= 20 && p < 45);
            end
            applyStimulus(w[0], r[0], 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), $urandom,
                          w[1], r[1], 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), $urandom);
        end
        idleCycles(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
